serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Datapath cell is a full subtractor built from two half-subtractor stages plus an OR on the borrows, with a registered borrow between bit steps.
- Pairs with the team's adder primitives. Used in the arithmetic test datapath where area matters more than latency.
- Start/busy/done handshake to the controller.

---
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, built from two half-subtractor stages per bit (optional ovf via SERIAL_SUB_SIGNED_OVF_EN).
// Latency: start accepted at E0, bits on E1..E_WIDTH, done pulses the cycle after; one op per WIDTH+2 cycles.
// Backpressure: none; start is honoured only in IDLE and dropped while busy or in DONE.

module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);
    assign d  = x ^ y;
    assign bo = ~x & y;
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sa, sb, sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [CW-1:0]    cnt;
    logic             bf;
    logic             last;

    // Full subtractor: two half-subtractor stages, borrows merged with OR.
    logic d1, b1, d, b2, bnext;

    half_subtractor u_hs0 (.x(sa[0]), .y(sb[0]), .d(d1), .bo(b1));
    half_subtractor u_hs1 (.x(d1),    .y(bf),    .d(d),  .bo(b2));

    assign bnext  = b1 | b2;
    assign sr_nxt = {d, sr[WIDTH-1:1]};
    assign last   = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // Operand sign bits are kept separately since SA/SB are shifted away.
    logic a_sign, b_sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
        end else if (state == RUN && last) begin
            ovf <= (a_sign != b_sign) && (d != a_sign);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            bf     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        bf  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    sr  <= sr_nxt;
                    bf  <= bnext;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        diff   <= sr_nxt;
                        borrow <= bnext;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of serial_subtractor at WIDTH=8: reset, arithmetic, ignored start, mid-run reset.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, borrow;
    logic [7:0] diff;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge; cyc=-1 on timeout.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
        end while (!done && cyc < 30);
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow} !== 11'h000) begin
            errors++;
            $display("FAIL reset_hold got busy=%b done=%b diff=%h borrow=%b want 0 0 00 0", busy, done, diff, borrow);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, diff, borrow} !== 11'h000) begin
            errors++;
            $display("FAIL reset_release got busy=%b done=%b diff=%h borrow=%b want 0 0 00 0", busy, done, diff, borrow);
        end
    endtask

    task automatic test_basic();
        int cyc, bc;
        launch(8'h05, 8'h03);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 9) begin errors++; $display("FAIL basic_done_cycle got %0d want 9", cyc); end
        checks++;
        if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %b want 0", busy); end
        checks++;
        if (diff !== 8'h02 || borrow !== 1'b0) begin
            errors++; $display("FAIL basic_result got %h/%b want 02/0", diff, borrow);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_single got %b want 0", done); end
        repeat (5) @(negedge clk);
        checks++;
        if (diff !== 8'h02 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_hold got diff=%h busy=%b want 02 0", diff, busy);
        end
    endtask

    task automatic test_arith();
        int cyc, bc;
        logic [7:0] av [3] = '{8'h03, 8'hA5, 8'h00};
        logic [7:0] bv [3] = '{8'h05, 8'hA5, 8'hFF};
        logic [7:0] ed [3] = '{8'hFE, 8'h00, 8'h01};
        logic       eb [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] prev = 8'h02;
        for (int i = 0; i < 3; i++) begin
            launch(av[i], bv[i]);
            repeat (4) @(negedge clk);
            checks++;
            if (diff !== prev) begin
                errors++; $display("FAIL arith_hold_in_run[%0d] got %h want %h", i, diff, prev);
            end
            wait_done(cyc, bc);
            checks++;
            if (cyc !== 5 || diff !== ed[i] || borrow !== eb[i]) begin
                errors++;
                $display("FAIL arith[%0d] got cyc=%0d diff=%h borrow=%b want cyc=5 diff=%h borrow=%b",
                         i, cyc, diff, borrow, ed[i], eb[i]);
            end
            prev = ed[i];
        end
    endtask

    task automatic test_ignore_start();
        int cyc, bc, pulses;
        launch(8'h10, 8'h01);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        repeat (2) @(negedge clk);
        start = 1'b0;
        a = 8'h33;
        b = 8'h77;
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 4 || diff !== 8'h0F || borrow !== 1'b0) begin
            errors++; $display("FAIL ignore_result got cyc=%0d diff=%h borrow=%b want cyc=4 diff=0f borrow=0", cyc, diff, borrow);
        end
        pulses = 0;
        bc = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) bc++;
        end
        checks++;
        if (pulses !== 0 || bc !== 0) begin
            errors++; $display("FAIL ignore_extra got pulses=%0d busy_cycles=%0d want 0 0", pulses, bc);
        end
    endtask

    task automatic test_reset_abort();
        int cyc, bc, pulses;
        launch(8'h40, 8'h20);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, diff, borrow} !== 11'h000) begin
            errors++; $display("FAIL abort_clear got busy=%b done=%b diff=%h borrow=%b want 0 0 00 0", busy, done, diff, borrow);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", pulses); end
        launch(8'h09, 8'h04);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 9 || diff !== 8'h05 || borrow !== 1'b0) begin
            errors++; $display("FAIL abort_restart got cyc=%0d diff=%h borrow=%b want 9 05 0", cyc, diff, borrow);
        end
    endtask

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    task automatic test_ovf();
        int cyc, bc;
        launch(8'h80, 8'h01);
        wait_done(cyc, bc);
        checks++;
        if (diff !== 8'h7F || borrow !== 1'b0 || ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_set got %h/%b/%b want 7f/0/1", diff, borrow, ovf);
        end
        launch(8'h7F, 8'h01);
        wait_done(cyc, bc);
        checks++;
        if (diff !== 8'h7E || ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got %h/%b want 7e/0", diff, ovf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_ignore_start();
        test_reset_abort();
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
